// File: rtl/time_set_multi.sv
// Time-set editor: captures the running time, edits one digit at a time from
// debounced buttons with auto-repeat, and pulses commit with the edited value.
module time_set_multi #(
  parameter int                              NUM_DIGITS   = 4,
  parameter int                              DIGIT_W      = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0]   MAX_VALUES   = 16'h5959,
  parameter bit                              WRAP         = 1'b1,
  parameter int                              REPEAT_DELAY = 50_000_000,
  parameter int                              REPEAT_RATE  = 10_000_000
) (
  input  logic                              MCLK,
  input  logic                              RESET,
  input  logic                              enable,
  input  logic                              inc,
  input  logic                              dec,
  input  logic                              left,
  input  logic                              right,
  input  logic [NUM_DIGITS*DIGIT_W-1:0]     cur_digits,
  output logic [NUM_DIGITS*DIGIT_W-1:0]     edit_digits,
  output logic [$clog2(NUM_DIGITS)-1:0]     location,
  output logic                              editing,
  output logic                              commit
);
  // state  | meaning
  // IDLE   | not editing, waiting for enable
  // LOAD   | one cycle, captured (clamped) time on display, cursor leftmost
  // EDIT   | buttons act on the digit under the cursor
  // COMMIT | one-cycle commit pulse, edit_digits holds the final value

  localparam int LOC_W   = $clog2(NUM_DIGITS);
  localparam int CNT_TOP = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);

  typedef enum logic [1:0] {IDLE, LOAD, EDIT, COMMIT} state_t;
  state_t state, state_nxt;

  logic inc_q, dec_q, left_q, right_q;
  logic rpt_act;
  logic [CNT_W-1:0] rpt_cnt;

  logic act, inc_only, dec_only, inc_press, dec_press, left_press, right_press;
  logic move_l, move_r, rpt_tc, step_up, step_dn;
  logic [LOC_W-1:0] sel;
  logic [DIGIT_W-1:0] dig_val, dig_max, dig_new;
  logic [NUM_DIGITS*DIGIT_W-1:0] load_val;

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = LOAD;
      LOAD:    state_nxt = EDIT;
      EDIT:    if (!enable) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign editing = (state == LOAD) || (state == EDIT);
  assign commit  = (state == COMMIT);

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      left_q  <= 1'b0;
      right_q <= 1'b0;
    end else begin
      inc_q   <= inc;
      dec_q   <= dec;
      left_q  <= left;
      right_q <= right;
    end
  end

  // Buttons only act in EDIT while enable is still high; the exit cycle is ignored.
  assign act         = (state == EDIT) && enable;
  assign inc_only    = inc & ~dec;
  assign dec_only    = dec & ~inc;
  assign inc_press   = inc_only & ~inc_q;
  assign dec_press   = dec_only & ~dec_q;
  assign left_press  = left & ~left_q;
  assign right_press = right & ~right_q;
  assign move_l      = act & left_press & ~right_press & (location != '0);
  assign move_r      = act & right_press & ~left_press & (location != LOC_W'(NUM_DIGITS - 1));
  assign rpt_tc      = rpt_act && (rpt_cnt == '0);
  assign step_up     = act & inc_only & (inc_press | (inc_q & rpt_tc));
  assign step_dn     = act & dec_only & (dec_press | (dec_q & rpt_tc));

  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      rpt_act <= 1'b0;
      rpt_cnt <= '0;
    end else if (!act || !(inc_only || dec_only) || move_l || move_r) begin
      rpt_act <= 1'b0;
      rpt_cnt <= '0;
    end else if (inc_press || dec_press) begin
      rpt_act <= 1'b1;
      rpt_cnt <= CNT_W'(REPEAT_DELAY - 1);
    end else if (rpt_act) begin
      if (rpt_cnt == '0) rpt_cnt <= CNT_W'(REPEAT_RATE - 1);
      else               rpt_cnt <= rpt_cnt - 1'b1;
    end
  end

  // Cursor 0 is the leftmost digit, which is the most significant index.
  assign sel     = LOC_W'(NUM_DIGITS - 1) - location;
  assign dig_val = edit_digits[sel*DIGIT_W +: DIGIT_W];
  assign dig_max = MAX_VALUES[sel*DIGIT_W +: DIGIT_W];

  always_comb begin
    dig_new = dig_val;
    if (step_up) begin
      if (dig_val >= dig_max) dig_new = WRAP ? '0 : dig_max;
      else                    dig_new = dig_val + 1'b1;
    end else if (step_dn) begin
      if (dig_val == '0)      dig_new = WRAP ? dig_max : '0;
      else                    dig_new = dig_val - 1'b1;
    end
  end

  always_comb begin
    load_val = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cur_digits[i*DIGIT_W +: DIGIT_W] > MAX_VALUES[i*DIGIT_W +: DIGIT_W])
        load_val[i*DIGIT_W +: DIGIT_W] = MAX_VALUES[i*DIGIT_W +: DIGIT_W];
      else
        load_val[i*DIGIT_W +: DIGIT_W] = cur_digits[i*DIGIT_W +: DIGIT_W];
    end
  end

  // Capture happens on the IDLE->LOAD edge so the value is already shown during LOAD.
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      edit_digits <= '0;
      location    <= '0;
    end else if (state == IDLE && enable) begin
      edit_digits <= load_val;
      location    <= '0;
    end else begin
      if (step_up || step_dn) edit_digits[sel*DIGIT_W +: DIGIT_W] <= dig_new;
      if (move_l)      location <= location - 1'b1;
      else if (move_r) location <= location + 1'b1;
    end
  end

endmodule

// File: doc/time_set_multi.md
Name: time_set_multi

Overview:
Parametrised time-set editor for the clock display path, generalising the fixed 4-digit mm:ss set block.
- Digit count, digit width, per-digit maximum, wrap/saturate mode and auto-repeat timing are all parameters.
- Captures the running time on entry to set mode, edits one digit at a time from debounced buttons, and emits a one-cycle commit pulse with the final value on exit.
- Sits between the button debouncers and the timekeeping counter's load port; drives the display blink cursor.

Parameters:
- NUM_DIGITS, 4: number of editable digits (2..8).
- DIGIT_W, 4: bits per digit.
- MAX_VALUES, 16'h5959: packed per-digit maximum, digit i at [i*DIGIT_W +: DIGIT_W]; default is min10=5, min01=9, sec10=5, sec01=9.
- WRAP, 1: 1 = wrap at max/0; 0 = saturate.
- REPEAT_DELAY, 50_000_000: MCLK cycles of continuous hold before the first auto-repeat step.
- REPEAT_RATE, 10_000_000: MCLK cycles between subsequent auto-repeat steps.

Ports:
- MCLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- enable  in  1  set-mode request (level).
- inc  in  1  increment button (debounced, synchronous to MCLK).
- dec  in  1  decrement button.
- left  in  1  cursor-left button.
- right  in  1  cursor-right button.
- cur_digits  in  NUM_DIGITS*DIGIT_W  running time; digit NUM_DIGITS-1 is leftmost.
- edit_digits  out  NUM_DIGITS*DIGIT_W  value being edited, registered.
- location  out  $clog2(NUM_DIGITS)  cursor; 0 = leftmost digit (index NUM_DIGITS-1).
- editing  out  1  high while in LOAD/EDIT.
- commit  out  1  one-cycle pulse; edit_digits is valid to load when it is high.

Behaviour:
- Reset: RESET asynchronous, active-high; clock MCLK. All of the following apply immediately on RESET assertion, including mid-edit; no commit is issued.
  - state = IDLE; edit_digits = 0; location = 0; editing = 0; commit = 0.
  - All button history and repeat counters = 0.
- Synchronous state machine, IDLE -> LOAD -> EDIT -> COMMIT -> IDLE:
  - IDLE: editing = 0. enable sampled high -> LOAD.
  - LOAD (1 cycle): capture cur_digits into edit_digits. Any captured digit greater than its max is clamped to its max. location = 0; editing = 1. Next state EDIT.
  - EDIT: editing = 1. Button actions apply here only. enable sampled low -> COMMIT; button inputs in that cycle are ignored.
  - COMMIT (1 cycle): commit = 1, edit_digits held, editing = 0. Next state IDLE.
  - enable re-asserted during COMMIT is acted on from IDLE on the following cycle.
- Edge detection: each button is registered once; a press is button = 1 with the previous sample = 0. The resulting effect is visible on outputs one MCLK after the press cycle.
- left/right:
  - Edge-only, no auto-repeat.
  - left decrements location, saturating at 0; right increments location, saturating at NUM_DIGITS-1.
  - left and right pressed in the same cycle: no move.
- inc/dec:
  - Act on the digit selected by location.
  - A press gives one step. Continuous hold then gives a step after REPEAT_DELAY cycles, and every REPEAT_RATE cycles after that.
  - The repeat counter resets on release or on a location change.
  - inc and dec both high: no step, repeat counter cleared.
  - WRAP = 1: inc at max -> 0; dec at 0 -> max.
  - WRAP = 0: inc at max holds max; dec at 0 holds 0.
  - Arithmetic is DIGIT_W bits wide; no carry or borrow into neighbouring digits.
- Digits not under the cursor never change during EDIT.
- edit_digits holds its value in IDLE after a commit; it is only reloaded in LOAD.
- cur_digits changing during EDIT has no effect.

Test Plan:
- Reset mid-edit:
  - Stimulus: enter EDIT, inc twice, assert RESET for 3 cycles.
  - Required response: all outputs 0 and state IDLE during RESET; commit never pulses.
- Load/commit:
  - Stimulus: cur_digits = 16'h4237, raise enable.
  - Required response: LOAD next cycle gives edit_digits = 16'h4237, editing = 1.
  - Stimulus: drop enable.
  - Required response: commit = 1 for exactly one cycle with 16'h4237.
- Wrap:
  - Stimulus: location = 0 with digit 5, inc press.
  - Required response: digit becomes 0, edit_digits = 16'h0237.
  - Stimulus: dec press.
  - Required response: digit returns to 5.
  - Stimulus: repeat at location 3 with digit 9, then 0.
  - Required response: wraps to 0, then back to 9.
- Saturate and clamp:
  - Stimulus: WRAP = 0, inc at max.
  - Required response: value unchanged.
  - Stimulus: cur_digits = 16'h7F59.
  - Required response: loads as 16'h5959.
- Cursor:
  - Stimulus: four right presses.
  - Required response: location 1, 2, 3, 3.
  - Stimulus: left and right together.
  - Required response: location unchanged.
  - Stimulus: left at 0.
  - Required response: location stays 0.
- Auto-repeat:
  - Stimulus: REPEAT_DELAY = 8, REPEAT_RATE = 4; hold inc for 20 cycles on a digit starting at 0.
  - Required response: steps at press+1, +8 and every 4 cycles after; digit = 4 on release.
  - Stimulus: inc and dec held together.
  - Required response: no steps.
